nonogram_level_sequencer: RTL and testbench

Top-level game sequencer for the 10x10 nonogram. It decides when the player may edit the grid and checks the painted grid against the current level's answer after every edit. On a match it holds a "solved" indication, then wipes the grid and advances the level. It sits between the control module (paint/block grid owner) and the display/status logic, replacing ad-hoc level-progression logic in the game top.

---
 rtl/nonogram_pkg.sv | 21 ++
 rtl/nonogram_answer_rom.sv | 19 +
 rtl/nonogram_level_sequencer.sv | 126 ++++++++++++
 tb/tb_nonogram_level_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/nonogram_pkg.sv
// Shared constants, level answers and sequencer state encoding for the 10x10 nonogram.
package nonogram_pkg;

    localparam int GRID_CELLS     = 100;
    localparam int NUM_LEVELS_MAX = 4;

    // Bit 99 is row 0 col 0, row-major.
    localparam logic [GRID_CELLS-1:0] LEVEL_0_ANSWER = 100'h55555_55555_55555_55555_55555;
    localparam logic [GRID_CELLS-1:0] LEVEL_1_ANSWER = 100'h01234_56789_ABCDE_F0123_45678;
    localparam logic [GRID_CELLS-1:0] LEVEL_2_ANSWER = 100'h3C3C3_C3C3C_3C3C3_C3C3C_3C3C3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WIPE    = 3'd1,
        ST_PLAY    = 3'd2,
        ST_CHECK   = 3'd3,
        ST_CLEARED = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_t;

endpackage

// File: rtl/nonogram_answer_rom.sv
// Combinational level -> answer grid lookup; unknown levels give an all-ones grid.
module nonogram_answer_rom
    import nonogram_pkg::*;
(
    input  logic [1:0]            level,
    output logic [GRID_CELLS-1:0] answer
);

    // Answer selection by level index.
    always_comb begin
        case (level)
            2'd0:    answer = LEVEL_0_ANSWER;
            2'd1:    answer = LEVEL_1_ANSWER;
            2'd2:    answer = LEVEL_2_ANSWER;
            default: answer = {GRID_CELLS{1'b1}};
        endcase
    end

endmodule

// File: rtl/nonogram_level_sequencer.sv
// Game sequencer: gates edits, checks each edited grid against the level answer,
// holds the solved indication, then wipes the grid and advances the level.
module nonogram_level_sequencer
    import nonogram_pkg::*;
#(
    parameter int HOLD_CYCLES = 100,
    parameter int NUM_LEVELS  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  restart,
    input  logic [GRID_CELLS-1:0] paint,
    input  logic                  grid_changed,
    output logic [1:0]            level,
    output logic                  edit_en,
    output logic                  grid_clr,
    output logic                  solved,
    output logic                  game_done
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [1:0]    LAST_LEVEL = 2'(NUM_LEVELS - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);

    seq_state_t            state_r, state_nx_s;
    logic [1:0]            level_r, level_nx_s;
    logic [CW-1:0]         cnt_r, cnt_nx_s;
    logic [GRID_CELLS-1:0] snap_r;
    logic                  snap_ld_s;
    logic [GRID_CELLS-1:0] answer_s;
    logic                  edit_en_r, grid_clr_r, solved_r, game_done_r;

    nonogram_answer_rom u_rom (
        .level  (level_r),
        .answer (answer_s)
    );

    // Next-state, level, counter and snapshot-load decode.
    always_comb begin
        state_nx_s = state_r;
        level_nx_s = level_r;
        cnt_nx_s   = cnt_r;
        snap_ld_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nx_s = ST_WIPE;
                    level_nx_s = 2'd0;
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_WIPE: state_nx_s = ST_PLAY;
            ST_PLAY: begin
                // restart has priority; the snapshot is then left alone
                if (restart) begin
                    state_nx_s = ST_WIPE;
                end else if (grid_changed) begin
                    state_nx_s = ST_CHECK;
                    snap_ld_s  = 1'b1;
                end else begin
                    state_nx_s = ST_PLAY;
                end
            end
            ST_CHECK: begin
                if (snap_r == answer_s) begin
                    state_nx_s = ST_CLEARED;
                    cnt_nx_s   = HOLD_LOAD;
                end else begin
                    state_nx_s = ST_PLAY;
                end
            end
            ST_CLEARED: begin
                if (cnt_r != {CW{1'b0}}) begin
                    cnt_nx_s = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end else if (level_r == LAST_LEVEL) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_WIPE;
                    level_nx_s = level_r + 2'd1;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, level, counter and snapshot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            level_r <= 2'd0;
            cnt_r   <= {CW{1'b0}};
            snap_r  <= {GRID_CELLS{1'b0}};
        end else begin
            state_r <= state_nx_s;
            level_r <= level_nx_s;
            cnt_r   <= cnt_nx_s;
            if (snap_ld_s) begin
                snap_r <= paint;
            end
        end
    end

    // Outputs registered from the next state so they track the state register exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edit_en_r   <= 1'b0;
            grid_clr_r  <= 1'b0;
            solved_r    <= 1'b0;
            game_done_r <= 1'b0;
        end else begin
            edit_en_r   <= (state_nx_s == ST_PLAY);
            grid_clr_r  <= (state_nx_s == ST_WIPE);
            solved_r    <= (state_nx_s == ST_CLEARED);
            game_done_r <= (state_nx_s == ST_DONE);
        end
    end

    assign level     = level_r;
    assign edit_en   = edit_en_r;
    assign grid_clr  = grid_clr_r;
    assign solved    = solved_r;
    assign game_done = game_done_r;

endmodule

// File: tb/tb_nonogram_level_sequencer.sv
// Randomized bench for nonogram_level_sequencer against a transaction-level game model.
module tb_nonogram_level_sequencer;
    import nonogram_pkg::*;

    localparam int HOLD = 40;
    localparam int NL   = 3;

    logic        clk = 1'b0;
    logic        rst, start, restart, grid_changed;
    logic [99:0] paint;
    logic [1:0]  level;
    logic        edit_en, grid_clr, solved, game_done;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          m_level;
    logic [99:0] m_snap;

    nonogram_level_sequencer #(.HOLD_CYCLES(HOLD), .NUM_LEVELS(NL)) dut (
        .clk(clk), .rst(rst), .start(start), .restart(restart), .paint(paint),
        .grid_changed(grid_changed), .level(level), .edit_en(edit_en),
        .grid_clr(grid_clr), .solved(solved), .game_done(game_done)
    );

    always #5 clk = ~clk;

    function automatic logic [99:0] answer_of(int l);
        case (l)
            0:       return LEVEL_0_ANSWER;
            1:       return LEVEL_1_ANSWER;
            2:       return LEVEL_2_ANSWER;
            default: return {100{1'b1}};
        endcase
    endfunction

    task automatic check(string tag, logic [99:0] obs, logic [99:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(string tag, bit e_edit, bit e_clr, bit e_solved, bit e_done, int e_level);
        check({tag, ".edit_en"},   100'(edit_en),   100'(e_edit));
        check({tag, ".grid_clr"},  100'(grid_clr),  100'(e_clr));
        check({tag, ".solved"},    100'(solved),    100'(e_solved));
        check({tag, ".game_done"}, 100'(game_done), 100'(e_done));
        check({tag, ".level"},     100'(level),     100'(e_level));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [99:0] rand_grid();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [99:0] wrong_grid(int l);
        logic [99:0] p;
        do begin
            if ($urandom_range(0, 1) == 0) begin
                p = rand_grid();
            end else begin
                p = answer_of(l);
                for (int i = 0; i < int'($urandom_range(1, 4)); i++) p[$urandom_range(0, 99)] ^= 1'b1;
            end
        end while (p == answer_of(l));
        return p;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // One edit transaction; a matching grid runs the full solved/advance sequence.
    task automatic edit(logic [99:0] p, bit poke);
        paint = p;
        grid_changed = 1'b1;
        cyc();
        grid_changed = 1'b0;
        m_snap = p;
        check("snap_capture", dut.snap_r, m_snap);
        check_outs("check", 1'b0, 1'b0, 1'b0, 1'b0, m_level);
        if (poke) begin
            paint = ~p;
            grid_changed = 1'b1;
        end
        cyc();
        grid_changed = 1'b0;
        check("snap_after_check", dut.snap_r, m_snap);
        if (p == answer_of(m_level)) begin
            int cnt = 0;
            while (solved === 1'b1 && cnt < HOLD + 5) begin
                cnt++;
                check_outs("cleared", 1'b0, 1'b0, 1'b1, 1'b0, m_level);
                if (cnt == HOLD / 2) begin
                    paint = rand_grid();
                    grid_changed = 1'b1;
                    cyc();
                    grid_changed = 1'b0;
                    check("snap_in_cleared", dut.snap_r, m_snap);
                end else begin
                    cyc();
                end
            end
            check("hold_len", 100'(cnt), 100'(HOLD));
            if (m_level == NL - 1) begin
                check_outs("done", 1'b0, 1'b0, 1'b0, 1'b1, m_level);
            end else begin
                m_level++;
                check_outs("wipe_next", 1'b0, 1'b1, 1'b0, 1'b0, m_level);
                cyc();
                check_outs("play_next", 1'b1, 1'b0, 1'b0, 1'b0, m_level);
            end
        end else begin
            check_outs("back_play", 1'b1, 1'b0, 1'b0, 1'b0, m_level);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; restart = 1'b0; grid_changed = 1'b0; paint = '0;
        m_level = 0; m_snap = '0;
        cyc();
        cyc();
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("reset.snap", dut.snap_r, 100'h0);
        rst = 1'b0;
        cyc();
        check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 0);

        pulse_start();
        check_outs("start_wipe", 1'b0, 1'b1, 1'b0, 1'b0, 0);
        cyc();
        check_outs("start_play", 1'b1, 1'b0, 1'b0, 1'b0, 0);

        // start is ignored outside IDLE/DONE
        pulse_start();
        check_outs("start_ignored", 1'b1, 1'b0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 6; i++) edit(wrong_grid(m_level), bit'($urandom_range(0, 1)));
        edit(answer_of(0), 1'b1);

        // restart beats grid_changed even when the paint would solve the level
        paint = answer_of(m_level);
        restart = 1'b1;
        grid_changed = 1'b1;
        cyc();
        restart = 1'b0;
        grid_changed = 1'b0;
        check_outs("restart_wipe", 1'b0, 1'b1, 1'b0, 1'b0, m_level);
        check("restart_snap", dut.snap_r, m_snap);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_outs("restart_play", 1'b1, 1'b0, 1'b0, 1'b0, m_level);
        end

        while (m_level < NL - 1) begin
            edit(wrong_grid(m_level), 1'b0);
            edit(answer_of(m_level), 1'b0);
        end
        edit(answer_of(m_level), 1'b0);

        for (int i = 0; i < 4; i++) begin
            paint = rand_grid();
            grid_changed = 1'b1;
            restart = bit'(i == 1);
            cyc();
            grid_changed = 1'b0;
            restart = 1'b0;
            check_outs("done_hold", 1'b0, 1'b0, 1'b0, 1'b1, NL - 1);
            check("done_snap", dut.snap_r, m_snap);
        end

        pulse_start();
        m_level = 0;
        check_outs("restart_game", 1'b0, 1'b1, 1'b0, 1'b0, 0);
        cyc();

        // Reset with the hold counter at 37 (third CLEARED cycle)
        paint = answer_of(0);
        grid_changed = 1'b1;
        cyc();
        grid_changed = 1'b0;
        cyc();
        cyc();
        cyc();
        check_outs("cleared_37", 1'b0, 1'b0, 1'b1, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        check_outs("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("async_rst.snap", dut.snap_r, 100'h0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_outs("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        end
        pulse_start();
        check_outs("post_rst_start", 1'b0, 1'b1, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
